// File: rtl/servo_pwm_pkg.sv
// rtl/servo_pwm_pkg.sv - shared FSM state type and timing helpers for the servo PWM block
package servo_pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    function automatic int f_min_cyc(input int min_us, input int clk_mhz);
        return min_us * clk_mhz;
    endfunction

    function automatic int f_step_cyc(input int min_us, input int max_us, input int clk_mhz,
                                      input int max_in);
        return ((max_us - min_us) * clk_mhz) / max_in;
    endfunction

    function automatic int f_frame_cyc(input int frame_us, input int clk_mhz);
        return frame_us * clk_mhz;
    endfunction

    function automatic int f_cnt_width(input int frame_cyc);
        return $clog2(frame_cyc);
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// rtl/servo_pwm_channel.sv - one servo channel: frame shadow, clip/mirror, width register, output flop
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int C_PWM_SIZE   = 8,
    parameter int C_PWM_MAX_IN = 200,
    parameter int C_MIN_CYC    = 50000,
    parameter int C_STEP_CYC   = 1000,
    parameter int C_CNT_W      = 21
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  i_load,
    input  logic                  i_active,
    input  logic [C_CNT_W-1:0]    i_cnt,
    input  logic [C_PWM_SIZE-1:0] i_pos,
    input  logic                  i_ch_en,
    input  logic                  i_complement,
    output logic                  o_pwm,
    output logic                  o_sat
);

    localparam logic [C_PWM_SIZE-1:0] C_MAX = C_PWM_SIZE'(C_PWM_MAX_IN);

    logic                  w_over;
    logic [C_PWM_SIZE-1:0] w_clip;
    logic [C_PWM_SIZE-1:0] w_pos;
    logic [C_CNT_W-1:0]    w_width;

    logic [C_CNT_W-1:0]    r_width;
    logic                  r_en;
    logic                  r_sat;
    logic                  r_pwm;

    assign w_over  = (i_pos > C_MAX);
    assign w_clip  = w_over ? C_MAX : i_pos;
    assign w_pos   = i_complement ? (C_MAX - w_clip) : w_clip;
    assign w_width = C_CNT_W'(C_MIN_CYC) + C_CNT_W'(w_pos) * C_CNT_W'(C_STEP_CYC);

    // On the load cycle the comparison uses the fresh width so count 0 is not lost.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_width <= '0;
            r_en    <= 1'b0;
            r_sat   <= 1'b0;
            r_pwm   <= 1'b0;
        end else if (i_load) begin
            r_width <= w_width;
            r_en    <= i_ch_en;
            r_sat   <= w_over;
            r_pwm   <= i_ch_en && (i_cnt < w_width);
        end else begin
            r_pwm   <= i_active && r_en && (i_cnt < r_width);
        end
    end

    assign o_pwm = r_pwm;
    assign o_sat = r_sat;

endmodule

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - N-channel servo PWM generator with shared frame timer and run/stop FSM
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int C_CHANNELS   = 6,
    parameter int C_PWM_SIZE   = 8,
    parameter int C_CLK_MHZ    = 100,
    parameter int C_PWM_MAX_IN = 200,
    parameter int C_MIN_US     = 500,
    parameter int C_MAX_US     = 2500,
    parameter int C_FRAME_US   = 20000
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             EN,
    input  logic [C_CHANNELS-1:0]            CH_EN,
    input  logic [C_CHANNELS-1:0]            COMPLEMENT,
    input  logic [C_CHANNELS*C_PWM_SIZE-1:0] PWM_IN,
    output logic [C_CHANNELS-1:0]            PWM_OUT,
    output logic                             FRAME_START,
    output logic                             BUSY,
    output logic [C_CHANNELS-1:0]            SAT
);

    localparam int MIN_CYC   = f_min_cyc(C_MIN_US, C_CLK_MHZ);
    localparam int STEP_CYC  = f_step_cyc(C_MIN_US, C_MAX_US, C_CLK_MHZ, C_PWM_MAX_IN);
    localparam int FRAME_CYC = f_frame_cyc(C_FRAME_US, C_CLK_MHZ);
    localparam int CNT_W     = f_cnt_width(FRAME_CYC);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_CYC - 1);

    generate
        if (MIN_CYC + C_PWM_MAX_IN * STEP_CYC >= FRAME_CYC) begin : g_bad_timing
            $error("servo_pwm_multi: longest pulse does not fit inside the frame");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last;
    logic               w_load;
    logic               w_active;

    assign w_last   = (r_cnt == C_LAST);
    assign w_load   = (r_state == RUN) && (r_cnt == '0);
    assign w_active = (r_state != IDLE);

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // STOP keeps counting so the frame in flight finishes with its pulses intact.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_last ? '0 : r_cnt + CNT_W'(1);
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (EN) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) begin
                    if (!EN) w_state_nxt = IDLE;
                end else if (!EN) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (EN)          w_state_nxt = RUN;
                else if (w_last) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign FRAME_START = w_load;
    assign BUSY        = w_active;

    generate
        for (genvar k = 0; k < C_CHANNELS; k++) begin : g_ch
            servo_pwm_channel #(
                .C_PWM_SIZE  (C_PWM_SIZE),
                .C_PWM_MAX_IN(C_PWM_MAX_IN),
                .C_MIN_CYC   (MIN_CYC),
                .C_STEP_CYC  (STEP_CYC),
                .C_CNT_W     (CNT_W)
            ) u_ch (
                .CLK         (CLK),
                .nRST        (nRST),
                .i_load      (w_load),
                .i_active    (w_active),
                .i_cnt       (r_cnt),
                .i_pos       (PWM_IN[k*C_PWM_SIZE +: C_PWM_SIZE]),
                .i_ch_en     (CH_EN[k]),
                .i_complement(COMPLEMENT[k]),
                .o_pwm       (PWM_OUT[k]),
                .o_sat       (SAT[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - directed self-checking bench for servo_pwm_multi at 1 MHz, 3 channels
module tb_servo_pwm_multi;

    logic        CLK;
    logic        nRST;
    logic        EN;
    logic [2:0]  CH_EN;
    logic [2:0]  COMPLEMENT;
    logic [23:0] PWM_IN;
    logic [2:0]  PWM_OUT;
    logic        FRAME_START;
    logic        BUSY;
    logic [2:0]  SAT;

    int total;
    int bad;
    int hi [3];
    int rises [3];
    int fs_cnt;
    logic [2:0] prev;

    servo_pwm_multi #(
        .C_CHANNELS(3),
        .C_CLK_MHZ (1)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .EN         (EN),
        .CH_EN      (CH_EN),
        .COMPLEMENT (COMPLEMENT),
        .PWM_IN     (PWM_IN),
        .PWM_OUT    (PWM_OUT),
        .FRAME_START(FRAME_START),
        .BUSY       (BUSY),
        .SAT        (SAT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (PWM_OUT[k] === 1'b1) hi[k]++;
            if (PWM_OUT[k] === 1'b1 && prev[k] !== 1'b1) rises[k]++;
        end
        prev = PWM_OUT;
        if (FRAME_START === 1'b1) fs_cnt++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 3; k++) begin
            hi[k]    = 0;
            rises[k] = 0;
        end
        fs_cnt = 0;
    endtask

    task automatic test_reset();
        nRST = 1'b1; EN = 1'b0; CH_EN = 3'b000; COMPLEMENT = 3'b000; PWM_IN = '0;
        prev = 3'b000;
        steps(3);
        total++; if (PWM_OUT !== 3'b000) begin bad++; $display("FAIL reset_pwm got=%b want=000", PWM_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
        total++; if (FRAME_START !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", FRAME_START); end
        total++; if (SAT !== 3'b000) begin bad++; $display("FAIL reset_sat got=%b want=000", SAT); end
        nRST = 1'b0;
        steps(2);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", BUSY); end
        total++; if (PWM_OUT !== 3'b000) begin bad++; $display("FAIL idle_pwm got=%b want=000", PWM_OUT); end
    endtask

    // Frame 1: 0/100/200 -> 500/1500/2500 cycles, period 20000.
    task automatic test_basic();
        int exp_hi [3];
        exp_hi = '{500, 1500, 2500};
        PWM_IN = {8'd200, 8'd100, 8'd0}; CH_EN = 3'b111; COMPLEMENT = 3'b000;
        EN = 1'b1;
        step();
        total++; if (FRAME_START !== 1'b1) begin bad++; $display("FAIL first_fs got=%b want=1", FRAME_START); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL run_busy got=%b want=1", BUSY); end
        clear_counts();
        steps(3000);
        PWM_IN = {8'd100, 8'd255, 8'd50}; CH_EN = 3'b011;
        steps(16999);
        for (int k = 0; k < 3; k++) begin
            total++; if (hi[k] !== exp_hi[k]) begin bad++; $display("FAIL basic_high ch%0d got=%0d want=%0d", k, hi[k], exp_hi[k]); end
            total++; if (rises[k] !== 1) begin bad++; $display("FAIL basic_rises ch%0d got=%0d want=1", k, rises[k]); end
        end
        total++; if (fs_cnt !== 0) begin bad++; $display("FAIL basic_fs_mid got=%0d want=0", fs_cnt); end
        step();
        total++; if (FRAME_START !== 1'b1) begin bad++; $display("FAIL period_fs got=%b want=1", FRAME_START); end
    endtask

    // Frame 2: mid-frame input edits ignored, ch1 saturates, ch2 disabled, EN dropped and re-raised.
    task automatic test_mid_change();
        int exp_hi [3];
        exp_hi = '{1000, 2500, 0};
        clear_counts();
        steps(300);
        PWM_IN = {8'd100, 8'd10, 8'd150}; CH_EN = 3'b111;
        steps(700);
        total++; if (SAT !== 3'b010) begin bad++; $display("FAIL sat_set got=%b want=010", SAT); end
        EN = 1'b0;
        steps(4000);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL stop_busy got=%b want=1", BUSY); end
        EN = 1'b1;
        steps(14999);
        for (int k = 0; k < 3; k++) begin
            total++; if (hi[k] !== exp_hi[k]) begin bad++; $display("FAIL mid_high ch%0d got=%0d want=%0d", k, hi[k], exp_hi[k]); end
        end
        total++; if (rises[0] !== 1) begin bad++; $display("FAIL mid_glitch ch0 rises got=%0d want=1", rises[0]); end
        total++; if (fs_cnt !== 0) begin bad++; $display("FAIL mid_fs got=%0d want=0", fs_cnt); end
        step();
        total++; if (FRAME_START !== 1'b1) begin bad++; $display("FAIL rerun_fs got=%b want=1", FRAME_START); end
    endtask

    // Frame 3: new values take effect, SAT clears, EN dropped -> frame finishes then idles.
    task automatic test_stop();
        int exp_hi [3];
        exp_hi = '{2000, 600, 1500};
        clear_counts();
        steps(1000);
        total++; if (SAT !== 3'b000) begin bad++; $display("FAIL sat_clear got=%b want=000", SAT); end
        EN = 1'b0;
        steps(18999);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL stop_last_busy got=%b want=1", BUSY); end
        for (int k = 0; k < 3; k++) begin
            total++; if (hi[k] !== exp_hi[k]) begin bad++; $display("FAIL stop_high ch%0d got=%0d want=%0d", k, hi[k], exp_hi[k]); end
        end
        step();
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL stop_wrap_busy got=%b want=0", BUSY); end
        total++; if (FRAME_START !== 1'b0) begin bad++; $display("FAIL stop_wrap_fs got=%b want=0", FRAME_START); end
        clear_counts();
        steps(200);
        total++; if (hi[0] + hi[1] + hi[2] !== 0) begin bad++; $display("FAIL idle_pulses got=%0d want=0", hi[0] + hi[1] + hi[2]); end
        total++; if (fs_cnt !== 0) begin bad++; $display("FAIL idle_fs got=%0d want=0", fs_cnt); end
    endtask

    // Complemented ch0, reset mid-pulse, restart from count 0.
    task automatic test_reset_mid();
        int exp_hi [3];
        exp_hi = '{2000, 500, 2500};
        PWM_IN = {8'd200, 8'd0, 8'd50}; COMPLEMENT = 3'b001; CH_EN = 3'b111;
        EN = 1'b1;
        step();
        total++; if (FRAME_START !== 1'b1) begin bad++; $display("FAIL restart_fs got=%b want=1", FRAME_START); end
        steps(800);
        total++; if (PWM_OUT !== 3'b101) begin bad++; $display("FAIL pre_reset_pwm got=%b want=101", PWM_OUT); end
        nRST = 1'b1;
        step();
        total++; if (PWM_OUT !== 3'b000) begin bad++; $display("FAIL midreset_pwm got=%b want=000", PWM_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", BUSY); end
        step();
        nRST = 1'b0;
        step();
        total++; if (FRAME_START !== 1'b1) begin bad++; $display("FAIL post_reset_fs got=%b want=1", FRAME_START); end
        clear_counts();
        steps(2600);
        for (int k = 0; k < 3; k++) begin
            total++; if (hi[k] !== exp_hi[k]) begin bad++; $display("FAIL comp_high ch%0d got=%0d want=%0d", k, hi[k], exp_hi[k]); end
        end
        nRST = 1'b1;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_counts();
        test_reset();
        test_basic();
        test_mid_change();
        test_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- N-channel hobby-servo PWM generator for the hexapod leg joints; one instance drives all joints of a leg group from the inverse-kinematics result registers.
- Single shared frame timer; each channel's pulse = fixed minimum + position × step, all pulses start together at frame start.
- Positions and modes are sampled only at frame boundaries (shadow registers), so outputs never glitch mid-pulse.
- New versus the single-channel generator: per-channel enable/complement, input saturation, graceful stop at end of frame, frame strobe.

Parameters:
- C_CHANNELS, 6: number of servo channels.
- C_PWM_SIZE, 8: bit width of each position input.
- C_CLK_MHZ, 100: clock frequency in MHz.
- C_PWM_MAX_IN, 200: full-scale position code.
- C_MIN_US, 500: pulse width (µs) at position 0.
- C_MAX_US, 2500: pulse width (µs) at position C_PWM_MAX_IN.
- C_FRAME_US, 20000: frame period (µs).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, synchronous, active-high (nRST=1 resets).
- EN  in  1  global run request.
- CH_EN  in  C_CHANNELS  per-channel enable, sampled at frame start.
- COMPLEMENT  in  C_CHANNELS  per-channel mirror (pos' = C_PWM_MAX_IN − pos), sampled at frame start.
- PWM_IN  in  C_CHANNELS*C_PWM_SIZE  packed positions; channel k occupies bits [k*C_PWM_SIZE +: C_PWM_SIZE].
- PWM_OUT  out  C_CHANNELS  registered servo outputs.
- FRAME_START  out  1  one-cycle strobe on the cycle shadows load.
- BUSY  out  1  high while in RUN or STOP.
- SAT  out  C_CHANNELS  sticky per channel; set when a sampled PWM_IN exceeds C_PWM_MAX_IN; cleared by reset or by a frame whose sample is in range.

Behaviour:
- Derived constants:
  - MIN_CYC = C_MIN_US*C_CLK_MHZ
  - STEP_CYC = (C_MAX_US−C_MIN_US)*C_CLK_MHZ/C_PWM_MAX_IN (integer division)
  - FRAME_CYC = C_FRAME_US*C_CLK_MHZ
  - Counter width = $clog2(FRAME_CYC).
  - Elaboration error if MIN_CYC + C_PWM_MAX_IN*STEP_CYC ≥ FRAME_CYC.
- Reset (nRST=1 on a clock edge):
  - state=IDLE, frame_cnt=0, all shadows 0.
  - PWM_OUT=0, FRAME_START=0, BUSY=0, SAT=0, all from the next edge.
  - Reset mid-pulse forces outputs low on that edge; no partial frame completes.
- FSM states: IDLE, RUN, STOP.
  - IDLE: outputs low, frame_cnt=0. EN=1 → RUN.
  - RUN: frame_cnt increments and wraps at FRAME_CYC−1 → 0. At the wrap, EN=0 → IDLE, otherwise stay in RUN.
  - EN falling mid-frame → STOP. STOP completes the current frame unchanged: STOP→IDLE at frame_cnt=FRAME_CYC−1; if EN returns to 1 during STOP, go back to RUN, keeping the same count.
- Frame load:
  - Occurs on the cycle frame_cnt==0 in RUN, including the first cycle after IDLE→RUN.
  - Per channel:
    - p = min(PWM_IN_k, C_PWM_MAX_IN).
    - If COMPLEMENT_k, p = C_PWM_MAX_IN − p.
    - width_k = MIN_CYC + p*STEP_CYC, registered.
    - en_k = CH_EN_k.
  - FRAME_START=1 for that cycle.
- Output:
  - PWM_OUT_k = en_k && (frame_cnt < width_k), registered: one cycle latency after frame_cnt.
  - High time is exactly width_k cycles per frame.
  - A disabled channel stays low for the whole frame.
- Input changes between loads have no effect on the current frame.
- Arithmetic: width computed unsigned at counter width; the product is computed at load time only (one multiplier per channel, or one shared multiplier sequenced over C_CHANNELS cycles). If sequenced, loading must finish before frame_cnt reaches MIN_CYC.

Decomposition:
- Package servo_pwm_pkg:
  - FSM state enum (IDLE/RUN/STOP).
  - Constant functions for MIN_CYC, STEP_CYC, FRAME_CYC and counter width.
- Sub-module servo_pwm_channel: shadow latch, saturation/complement, width register, comparator, output flop. Instantiated C_CHANNELS times by a generate loop.
- Top owns the FSM, frame counter and FRAME_START.

Test Plan:
- Bench params: C_CLK_MHZ=1, C_CHANNELS=3 → MIN_CYC=500, STEP_CYC=10, FRAME_CYC=20000.
- PWM_IN={0,100,200}, CH_EN=3'b111, EN=1 → pulse highs of 500/1500/2500 cycles; period 20000; FRAME_START every 20000 cycles.
- PWM_IN_0 changed 50→150 at cycle 300 of a frame → current frame high 1000; next frame 2000; no glitch.
- COMPLEMENT=3'b001, PWM_IN_0=50 → high 2000 cycles. PWM_IN_1=255 → high 2500 cycles, SAT[1]=1; PWM_IN_1=10 next frame → SAT[1]=0.
- EN dropped at frame_cnt=1000 → current frame completes with all pulses intact, BUSY falls at the wrap, no further pulses. EN re-raised during STOP → continuous frames.
- nRST=1 at frame_cnt=800 while channel high → PWM_OUT=0 next edge, BUSY=0; after release with EN=1, a new frame starts from count 0.
- CH_EN[2]=0 at frame load → channel 2 stays low all frame; channels 0 and 1 unaffected.
